// File: rtl/mmio_axi_bridge.sv
// Purpose: converts one held MMIO request into one single-beat AXI4 read or write; one transaction outstanding at a time.
// Latency: 3 cycles from request to resp_finish with zero-wait slave (IDLE -> addr phase -> data/resp phase -> DONE).
// Backpressure: each AXI valid is held until its ready; the requester holds its level until resp_finish. Optional timeout macro: MMIO_TIMEOUT_EN.
module mmio_axi_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [3:0]  AXI_ID = 4'b0001
`ifdef MMIO_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1023
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_data,
  input  logic [7:0]        req_mask,
  input  logic              req_we,
  input  logic              req_re,
  output logic [63:0]       resp_data,
  output logic              resp_finish,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awid,
  output logic [2:0]        awsize,
  output logic [7:0]        awlen,
  output logic              wvalid,
  input  logic              wready,
  output logic [63:0]       wdata,
  output logic [7:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [2:0]        arsize,
  output logic [7:0]        arlen,
  input  logic              rvalid,
  output logic              rready,
  input  logic [63:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast
`ifdef MMIO_TIMEOUT_EN
  , output logic            resp_err
`endif
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        mask_q;
  logic              aw_done, w_done;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic              start;
  logic              tmo;

  // Single-beat 32-bit transfers only; these fields never change.
  assign awid   = AXI_ID;
  assign arid   = AXI_ID;
  assign awsize = 3'b010;
  assign arsize = 3'b010;
  assign awlen  = 8'h00;
  assign arlen  = 8'h00;
  assign wlast  = 1'b1;

  assign awaddr = addr_q;
  assign araddr = addr_q;
  // The 32-bit word sits in the 64-bit lane selected by address bit 2.
  assign wdata  = addr_q[2] ? {data_q, 32'h0} : {32'h0, data_q};
  assign wstrb  = addr_q[2] ? {mask_q, 4'h0} : {4'h0, mask_q};

  assign ar_hs = arvalid & arready;
  assign r_hs  = rready  & rvalid;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;
  assign b_hs  = bready  & bvalid;
  assign start = (state == IDLE) & (req_we | req_re);

  // Unused request bits and response codes that carry no information for this bridge.
  logic unused_ok;
  assign unused_ok = ^{req_addr, req_data[63:32], req_mask[7:4], rresp, bresp, rlast};

`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             busy;
  assign busy = (state == RD_A) | (state == RD_D) | (state == WR_AW) | (state == WR_B);
  assign tmo  = busy & (cnt == CNT_W'(TIMEOUT_CYC));

  // Wait counter: held at zero in IDLE so it starts from zero on entry to RD_A/WR_AW.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) cnt <= '0;
    else if (busy)            cnt <= cnt + 1'b1;
  end

  // Sticky error: timeout or any non-OKAY response.
  always_ff @(posedge clk) begin
    if (rst) resp_err <= 1'b0;
    else if (tmo || (r_hs && rresp != 2'b00) || (b_hs && bresp != 2'b00)) resp_err <= 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; writes win when both request levels are high.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_we) state_nxt = WR_AW;
             else if (req_re) state_nxt = RD_A;
      RD_A:  if (tmo) state_nxt = DONE;
             else if (ar_hs) state_nxt = RD_D;
      RD_D:  if (tmo || r_hs) state_nxt = DONE;
      WR_AW: if (tmo) state_nxt = DONE;
             else if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = WR_B;
      WR_B:  if (tmo || b_hs) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Channel outputs decoded from state; a timeout cycle withdraws every valid/ready.
  always_comb begin
    arvalid     = (state == RD_A)  & ~tmo;
    rready      = (state == RD_D)  & ~tmo;
    awvalid     = (state == WR_AW) & ~aw_done & ~tmo;
    wvalid      = (state == WR_AW) & ~w_done  & ~tmo;
    bready      = (state == WR_B)  & ~tmo;
    resp_finish = (state == DONE);
  end

  // Request capture on leaving IDLE; later changes to req_* are ignored until DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else if (start) begin
      addr_q <= req_addr[ADDR_W-1:0];
      data_q <= req_data[31:0];
      mask_q <= req_mask[3:0];
    end
  end

  // Per-channel completion flags so AW and W drop independently.
  always_ff @(posedge clk) begin
    if (rst || state != WR_AW) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Read result register; writes leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) resp_data <= '0;
    else if (r_hs) resp_data <= {32'h0, (addr_q[2] ? rdata[63:32] : rdata[31:0])};
`ifdef MMIO_TIMEOUT_EN
    else if (tmo && (state == RD_A || state == RD_D)) resp_data <= 64'h0000_0000_DEAD_BEEF;
`endif
  end

endmodule

// File: doc/mmio_axi_bridge.md
Name: mmio_axi_bridge

Overview:
- Downstream of the uncached/MMIO splitter. Consumes its arbiter-side request (arb_addr/arb_data/arb_mask/arb_we/arb_re) and returns read data plus a finish strobe.
- Converts each request into one single-beat AXI4 read or write to the UART/SPI/CLINT space.
- Only one transaction is outstanding at a time. Requests are level-held by the requester until finish.

Parameters:
- ADDR_W, 32, width of the AXI address; taken from req_addr[ADDR_W-1:0].
- AXI_ID, 4'b0001, constant ID driven on awid/arid.
- TIMEOUT_CYC, 1023, cycles to wait for a response before forcing completion (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_addr  in  64  request byte address
- req_data  in  64  write data; the active 32-bit word is in [31:0]
- req_mask  in  8  byte strobes, relative to the 32-bit word
- req_we  in  1  write request, level-held until resp_finish
- req_re  in  1  read request, level-held until resp_finish
- resp_data  out  64  read result, {32'h0, word}
- resp_finish  out  1  one-cycle completion pulse
- awvalid out 1; awready in 1; awaddr out ADDR_W; awid out 4; awsize out 3; awlen out 8
- wvalid out 1; wready in 1; wdata out 64; wstrb out 8; wlast out 1
- bvalid in 1; bready out 1; bresp in 2
- arvalid out 1; arready in 1; araddr out ADDR_W; arid out 4; arsize out 3; arlen out 8
- rvalid in 1; rready out 1; rdata in 64; rresp in 2; rlast in 1
- resp_err  out  1  sticky error flag (optional feature only)

Behaviour:
- Reset values: all valid/ready outputs 0; resp_finish 0; resp_data 0; state IDLE. awsize = arsize = 3'b010 and awlen = arlen = 0 constant; wlast = 1 constant.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE:
  - req_we=1 -> WR_AW; write takes priority if both we and re are 1.
  - else req_re=1 -> RD_A.
  - Request fields are latched into internal registers on leaving IDLE. Later changes to req_* are ignored until DONE.
- RD_A: arvalid=1 and araddr=latched addr, held until arready. On the handshake cycle: arvalid drops next cycle, go to RD_D.
- RD_D: rready=1. On rvalid:
  - word = rdata[63:32] if addr[2]=1, else rdata[31:0].
  - resp_data <= {32'h0, word}; go to DONE.
- WR_AW: awvalid and wvalid asserted together in the first cycle.
  - Each channel drops independently after its own handshake; a same-cycle handshake on both is allowed.
  - wdata = addr[2] ? {data[31:0], 32'h0} : {32'h0, data[31:0]}.
  - wstrb = mask[3:0] shifted to lanes [7:4] if addr[2]=1, else lanes [3:0].
  - Once both AW and W handshakes are done, go to WR_B.
- WR_B: bready=1; on bvalid -> DONE.
- DONE: resp_finish=1 for exactly this cycle, then IDLE unconditionally. The request is not sampled in DONE, which prevents re-issue while the requester drops its level.
- resp_data holds its value until the next completed read. Writes leave resp_data unchanged.
- Latency with zero-wait slaves: read = 3 cycles from req_re to resp_finish; write = 3 cycles from req_we to resp_finish.
- Nonzero rresp/bresp: transaction still completes normally; the read data is returned as received.
- rvalid/bvalid arriving in states where they are not expected are ignored (the corresponding ready is 0).
- rst asserted mid-transaction:
  - Immediate return to IDLE and all valids drop. No finish is issued.
  - The slave-side outstanding transaction is abandoned; system reset covers the slave.

Optional Feature:
- Macro: MMIO_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RD_A/WR_AW and increments each cycle in RD_A, RD_D, WR_AW and WR_B.
  - When the counter reaches TIMEOUT_CYC: drop all valids/readies and go to DONE. For a read, resp_data = 64'h0000_0000_DEAD_BEEF.
  - resp_err is set on timeout or on nonzero rresp/bresp, and cleared only by rst.
- Undefined: no counter and no resp_err port; the bridge waits indefinitely.

Test Plan:
- Read, addr 0x1000_0004, slave returns rdata=0x1122_3344_5566_7788 with zero wait -> araddr=0x1000_0004, resp_data=0x0000_0000_1122_3344, resp_finish high exactly one cycle, 3 cycles after req_re.
- Write, addr 0x0200_4000, data 0x0000_0000_AABB_CCDD, mask 0x0F; awready delayed 3 cycles, wready immediate -> wdata=0x0000_0000_AABB_CCDD, wstrb=0x0F, wvalid drops after 1 cycle, awvalid stays high until its handshake, single finish after bvalid.
- Write to addr 0x0200_4004, mask 0x03 -> wdata=0xAABB_CCDD_0000_0000, wstrb=0x30.
- req_we=req_re=1 simultaneously -> write is performed first; the read issues only after DONE if the requester still holds re.
- rst asserted while in RD_D -> next cycle all outputs at reset values, no resp_finish.
- MMIO_TIMEOUT_EN defined, TIMEOUT_CYC=16, slave never asserts arready -> resp_finish at cycle 17 after RD_A entry, resp_data=0xDEAD_BEEF, resp_err=1 and remains 1 until rst.
